// File: rtl/aes_iter_core.sv
// Iterative AES encryption core: one round per three cycles (SubBytes/ShiftRows, MixColumns, AddRoundKey).
// Round keys are fetched externally through key_idx/key_round.
module aes_iter_core #(
    parameter int unsigned NR = 10
) (
    input  logic         clk,
    input  logic         kill_n,
    input  logic         kill,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic [3:0]   key_idx,
    input  logic [127:0] key_round,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    localparam int unsigned BLK_W = 128;
    localparam logic [3:0]  NR_L  = 4'(NR);

    if (!(NR == 10 || NR == 12 || NR == 14)) begin : g_bad_nr
        $error("aes_iter_core: NR must be 10, 12 or 14");
    end

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [2:0] {IDLE, SUB, MIX, ADD, DONE} fsm_t;

    fsm_t             fsm;
    logic [3:0]       rnd;
    logic [BLK_W-1:0] state;
    logic [BLK_W-1:0] stage1;
    logic [BLK_W-1:0] stage2;

    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Byte n of a block sits at bits [127-8n -: 8]; byte n is row n%4, column n/4
    function automatic logic [BLK_W-1:0] sub_shift(input logic [BLK_W-1:0] s);
        logic [BLK_W-1:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int rw = 0; rw < 4; rw++) begin
                r[127-8*(rw+4*c) -: 8] = SBOX[s[127-8*(rw+4*((c+rw)%4)) -: 8]];
            end
        end
        return r;
    endfunction

    function automatic logic [BLK_W-1:0] mix_columns(input logic [BLK_W-1:0] s);
        logic [BLK_W-1:0] r;
        logic [7:0]       a0, a1, a2, a3;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            r[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                                 a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                                 a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                                 xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
        end
        return r;
    endfunction

    // Round controller and datapath; rnd returns to 0 in IDLE so it doubles as key_idx
    always_ff @(posedge clk or negedge kill_n) begin
        if (!kill_n) begin
            fsm       <= IDLE;
            rnd       <= '0;
            state     <= '0;
            stage1    <= '0;
            stage2    <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
        end else if (kill) begin
            fsm       <= IDLE;
            rnd       <= '0;
            state     <= '0;
            stage1    <= '0;
            stage2    <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
        end else begin
            case (fsm)
                IDLE: begin
                    if (in_valid) begin
                        state    <= in_data ^ key_round;
                        rnd      <= 4'd1;
                        fsm      <= SUB;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                SUB: begin
                    stage1 <= sub_shift(state);
                    fsm    <= MIX;
                end
                MIX: begin
                    stage2 <= (rnd == NR_L) ? stage1 : mix_columns(stage1);
                    fsm    <= ADD;
                end
                ADD: begin
                    state <= stage2 ^ key_round;
                    if (rnd == NR_L) begin
                        fsm       <= DONE;
                        out_valid <= 1'b1;
                    end else begin
                        rnd <= rnd + 4'd1;
                        fsm <= SUB;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        fsm       <= IDLE;
                        rnd       <= '0;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end

    assign key_idx  = rnd;
    assign out_data = state;

endmodule

// File: tb/tb_aes_iter_core.sv
// Bench for aes_iter_core: AES-128 and AES-256 instances against a byte-level AES model.
module tb_aes_iter_core;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         kill_n;
    logic         d_kill, d_in_valid, d_out_ready;
    logic [127:0] d_in_data;
    bit           use14;
    int           cur_nr;
    logic [127:0] rk [0:15];
    logic [7:0]   sb [0:255];
    logic [31:0]  kw [0:59];
    int           checks = 0;
    int           errors = 0;

    logic         a_in_valid, a_out_ready, a_kill, a_in_ready, a_out_valid, a_busy;
    logic [3:0]   a_key_idx;
    logic [127:0] a_in_data, a_key_round, a_out_data;
    logic         b_in_valid, b_out_ready, b_kill, b_in_ready, b_out_valid, b_busy;
    logic [3:0]   b_key_idx;
    logic [127:0] b_in_data, b_key_round, b_out_data;

    assign a_in_valid  = d_in_valid & ~use14;
    assign a_out_ready = d_out_ready & ~use14;
    assign a_kill      = d_kill & ~use14;
    assign a_in_data   = d_in_data;
    assign a_key_round = rk[a_key_idx];
    assign b_in_valid  = d_in_valid & use14;
    assign b_out_ready = d_out_ready & use14;
    assign b_kill      = d_kill & use14;
    assign b_in_data   = d_in_data;
    assign b_key_round = rk[b_key_idx];

    wire         o_in_ready  = use14 ? b_in_ready  : a_in_ready;
    wire         o_out_valid = use14 ? b_out_valid : a_out_valid;
    wire         o_busy      = use14 ? b_busy      : a_busy;
    wire [3:0]   o_key_idx   = use14 ? b_key_idx   : a_key_idx;
    wire [127:0] o_out_data  = use14 ? b_out_data  : a_out_data;

    aes_iter_core #(.NR(10)) dut (
        .clk(clk), .kill_n(kill_n), .kill(a_kill),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .key_idx(a_key_idx), .key_round(a_key_round),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .busy(a_busy)
    );

    aes_iter_core #(.NR(14)) dut14 (
        .clk(clk), .kill_n(kill_n), .kill(b_kill),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .key_idx(b_key_idx), .key_round(b_key_round),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .busy(b_busy)
    );

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p ^= a;
            a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv, x;
        for (int v = 0; v < 256; v++) begin
            x = 8'(v);
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (v != 0 && gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
            sb[v] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
    endfunction

    // Key schedule; key is left-aligned in a 256-bit vector
    task automatic expand_key(input logic [255:0] key, input int nr);
        int nk;
        logic [31:0] t;
        logic [7:0] rc;
        nk = nr - 6;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) kw[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            t = kw[i-1];
            if (i % nk == 0) begin
                t = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                t = sub_word(t);
            end
            kw[i] = kw[i-nk] ^ t;
        end
        for (int r = 0; r < 16; r++)
            rk[r] = (r <= nr) ? {kw[4*r], kw[4*r+1], kw[4*r+2], kw[4*r+3]} : 128'h0;
        cur_nr = nr;
    endtask

    function automatic logic [127:0] aes_ref(input logic [127:0] pt);
        logic [7:0]   s [0:15];
        logic [7:0]   t [0:15];
        logic [127:0] res;
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ rk[0][127-8*i -: 8];
        for (int r = 1; r <= cur_nr; r++) begin
            for (int c = 0; c < 4; c++)
                for (int w = 0; w < 4; w++)
                    t[w+4*c] = sb[s[w+4*((c+w)%4)]];
            if (r < cur_nr) begin
                for (int c = 0; c < 4; c++) begin
                    s[4*c]   = gmul(8'h02, t[4*c]) ^ gmul(8'h03, t[4*c+1]) ^ t[4*c+2] ^ t[4*c+3];
                    s[4*c+1] = t[4*c] ^ gmul(8'h02, t[4*c+1]) ^ gmul(8'h03, t[4*c+2]) ^ t[4*c+3];
                    s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(8'h02, t[4*c+2]) ^ gmul(8'h03, t[4*c+3]);
                    s[4*c+3] = gmul(8'h03, t[4*c]) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(8'h02, t[4*c+3]);
                end
            end else begin
                for (int i = 0; i < 16; i++) s[i] = t[i];
            end
            for (int i = 0; i < 16; i++) s[i] ^= rk[r][127-8*i -: 8];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        checks++;
        if (o_in_ready !== 1'b1 || o_out_valid !== 1'b0 || o_busy !== 1'b0 || o_key_idx !== 4'd0) begin
            errors++;
            $display("FAIL reset got rdy=%b ov=%b busy=%b kidx=%0d exp 1 0 0 0",
                     o_in_ready, o_out_valid, o_busy, o_key_idx);
        end
        kill_n = 1'b1;
        tick();
    endtask

    // One full encryption from IDLE with a stall of 'stall' cycles before out_ready
    task automatic run_block(input logic [127:0] pt, input logic [127:0] exp_ct, input int stall);
        int lat;
        d_in_valid = 1'b1;
        d_in_data  = pt;
        checks++;
        if (o_in_ready !== 1'b1 || o_key_idx !== 4'd0) begin
            errors++;
            $display("FAIL idle got rdy=%b kidx=%0d exp 1 0", o_in_ready, o_key_idx);
        end
        tick();
        lat = 0;
        while (o_out_valid !== 1'b1 && lat < 3*cur_nr + 10) begin
            checks++;
            if (o_in_ready !== 1'b0 || o_busy !== 1'b1 || o_key_idx !== 4'(lat/3 + 1)) begin
                errors++;
                $display("FAIL busy_cycle%0d got rdy=%b busy=%b kidx=%0d exp 0 1 %0d",
                         lat, o_in_ready, o_busy, o_key_idx, lat/3 + 1);
            end
            d_in_valid  = 1'($urandom);
            d_in_data   = rand128();
            d_out_ready = 1'($urandom);
            tick();
            lat++;
        end
        d_in_valid  = 1'b0;
        d_out_ready = 1'b0;
        checks++;
        if (lat != 3*cur_nr) begin
            errors++;
            $display("FAIL latency got %0d exp %0d", lat, 3*cur_nr);
        end
        checks++;
        if (o_out_data !== exp_ct) begin
            errors++;
            $display("FAIL ciphertext got %h exp %h", o_out_data, exp_ct);
        end
        for (int i = 0; i < stall; i++) begin
            tick();
            checks++;
            if (o_out_valid !== 1'b1 || o_out_data !== exp_ct || o_in_ready !== 1'b0 ||
                o_key_idx !== 4'(cur_nr)) begin
                errors++;
                $display("FAIL stall%0d got ov=%b data=%h rdy=%b kidx=%0d exp 1 %h 0 %0d",
                         i, o_out_valid, o_out_data, o_in_ready, o_key_idx, exp_ct, cur_nr);
            end
        end
        d_out_ready = 1'b1;
        tick();
        d_out_ready = 1'b0;
        checks++;
        if (o_out_valid !== 1'b0 || o_in_ready !== 1'b1 || o_busy !== 1'b0 || o_key_idx !== 4'd0) begin
            errors++;
            $display("FAIL handshake got ov=%b rdy=%b busy=%b kidx=%0d exp 0 1 0 0",
                     o_out_valid, o_in_ready, o_busy, o_key_idx);
        end
    endtask

    task automatic watch_no_output(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (o_out_valid === 1'b1) seen = 1'b1;
            tick();
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL %s got out_valid=1 after abort exp never", name);
        end
    endtask

    task automatic test_fips_vectors();
        expand_key({128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 10);
        run_block(128'h3243f6a8885a308d313198a2e0370734, 128'h3925841d02dc09fbdc118597196a0b32, 0);
        expand_key({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 10);
        run_block(128'h00112233445566778899aabbccddeeff, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 5);
    endtask

    task automatic test_nr14();
        use14 = 1'b1;
        expand_key(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 14);
        run_block(128'h00112233445566778899aabbccddeeff, 128'h8ea2b7ca516745bfeafc49904b496089, 2);
        expand_key({rand128(), rand128()}, 14);
        d_in_data = rand128();
        run_block(d_in_data, aes_ref(d_in_data), 1);
        use14 = 1'b0;
    endtask

    task automatic test_random();
        logic [127:0] pt;
        for (int n = 0; n < 6; n++) begin
            expand_key({rand128(), 128'h0}, 10);
            pt = rand128();
            repeat ($urandom_range(0, 2)) tick();
            run_block(pt, aes_ref(pt), int'($urandom_range(0, 3)));
        end
    endtask

    task automatic test_kill();
        logic [127:0] pt;
        expand_key({rand128(), 128'h0}, 10);
        d_in_valid = 1'b1;
        d_kill     = 1'b1;
        d_in_data  = rand128();
        tick();
        d_kill = 1'b0;
        d_in_valid = 1'b0;
        checks++;
        if (o_in_ready !== 1'b1 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL kill_vs_in_valid got rdy=%b busy=%b exp 1 0", o_in_ready, o_busy);
        end
        d_in_valid = 1'b1;
        tick();
        d_in_valid = 1'b0;
        repeat (13) tick();
        checks++;
        if (o_key_idx !== 4'd5 || o_busy !== 1'b1) begin
            errors++;
            $display("FAIL kill_setup got kidx=%0d busy=%b exp 5 1", o_key_idx, o_busy);
        end
        d_kill = 1'b1;
        tick();
        d_kill = 1'b0;
        checks++;
        if (o_in_ready !== 1'b1 || o_busy !== 1'b0 || o_out_valid !== 1'b0 ||
            o_key_idx !== 4'd0 || o_out_data !== 128'h0) begin
            errors++;
            $display("FAIL kill_mix got rdy=%b busy=%b ov=%b kidx=%0d data=%h exp 1 0 0 0 0",
                     o_in_ready, o_busy, o_out_valid, o_key_idx, o_out_data);
        end
        watch_no_output("kill_mix_quiet");
        pt = rand128();
        run_block(pt, aes_ref(pt), 1);
        // Abort in DONE while out_ready is also high: kill wins and clears the data
        pt = rand128();
        d_in_valid = 1'b1;
        d_in_data  = pt;
        tick();
        d_in_valid = 1'b0;
        for (int i = 0; i < 40 && o_out_valid !== 1'b1; i++) tick();
        checks++;
        if (o_out_valid !== 1'b1 || o_out_data !== aes_ref(pt)) begin
            errors++;
            $display("FAIL kill_done_setup got ov=%b data=%h exp 1 %h", o_out_valid, o_out_data, aes_ref(pt));
        end
        d_kill = 1'b1;
        d_out_ready = 1'b1;
        tick();
        d_kill = 1'b0;
        d_out_ready = 1'b0;
        checks++;
        if (o_out_valid !== 1'b0 || o_in_ready !== 1'b1 || o_out_data !== 128'h0) begin
            errors++;
            $display("FAIL kill_done got ov=%b rdy=%b data=%h exp 0 1 0", o_out_valid, o_in_ready, o_out_data);
        end
    endtask

    task automatic test_kill_n();
        logic [127:0] pt;
        expand_key({rand128(), 128'h0}, 10);
        d_in_valid = 1'b1;
        d_in_data  = rand128();
        tick();
        d_in_valid = 1'b0;
        repeat (7) tick();
        checks++;
        if (o_key_idx !== 4'd3) begin
            errors++;
            $display("FAIL kill_n_setup got kidx=%0d exp 3", o_key_idx);
        end
        kill_n = 1'b0;
        #1;
        checks++;
        if (o_in_ready !== 1'b1 || o_busy !== 1'b0 || o_out_valid !== 1'b0 ||
            o_key_idx !== 4'd0 || o_out_data !== 128'h0) begin
            errors++;
            $display("FAIL kill_n_async got rdy=%b busy=%b ov=%b kidx=%0d data=%h exp 1 0 0 0 0",
                     o_in_ready, o_busy, o_out_valid, o_key_idx, o_out_data);
        end
        #2;
        kill_n = 1'b1;
        tick();
        watch_no_output("kill_n_quiet");
        pt = rand128();
        run_block(pt, aes_ref(pt), 0);
    endtask

    task automatic test_back_to_back();
        logic [127:0] pt [0:1];
        logic [127:0] got [0:1];
        int acc_t [0:1];
        int nacc, nout;
        bit acc_now;
        expand_key({rand128(), 128'h0}, 10);
        pt[0] = rand128();
        pt[1] = rand128();
        nacc = 0;
        nout = 0;
        acc_t[0] = 0;
        acc_t[1] = 0;
        got[0] = '0;
        got[1] = '0;
        d_in_valid  = 1'b1;
        d_in_data   = pt[0];
        d_out_ready = 1'b1;
        for (int i = 0; i < 200 && nout < 2; i++) begin
            acc_now = (o_in_ready === 1'b1) && d_in_valid && nacc < 2;
            if (acc_now) begin
                acc_t[nacc] = i;
                nacc++;
            end
            if (o_out_valid === 1'b1) begin
                got[nout] = o_out_data;
                nout++;
            end
            tick();
            if (acc_now && nacc == 1) d_in_data = pt[1];
            if (acc_now && nacc == 2) d_in_valid = 1'b0;
        end
        d_in_valid  = 1'b0;
        d_out_ready = 1'b0;
        checks++;
        if (nacc != 2 || acc_t[1] - acc_t[0] != 32) begin
            errors++;
            $display("FAIL b2b_interval got accepts=%0d gap=%0d exp 2 32", nacc, acc_t[1] - acc_t[0]);
        end
        checks++;
        if (got[0] !== aes_ref(pt[0]) || got[1] !== aes_ref(pt[1])) begin
            errors++;
            $display("FAIL b2b_data got %h %h exp %h %h", got[0], got[1], aes_ref(pt[0]), aes_ref(pt[1]));
        end
    endtask

    initial begin
        kill_n      = 1'b0;
        d_kill      = 1'b0;
        d_in_valid  = 1'b0;
        d_out_ready = 1'b0;
        d_in_data   = '0;
        use14       = 1'b0;
        cur_nr      = 10;
        for (int r = 0; r < 16; r++) rk[r] = '0;
        build_sbox();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_fips_vectors();
        test_nr14();
        test_random();
        test_kill();
        test_kill_n();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_iter_core.md
AES_ITER_CORE -- requirements
Module: aes_iter_core

Interface
REQ-001 The module SHALL provide parameter NR, default 10, meaning AES round count (10/12/14 for 128/192/256-bit keys); any other value SHALL cause an elaboration error.
REQ-002 clk  input  1  rising-edge clock; one clock only.
REQ-003 kill_n  input  1  reset, asynchronous and active-low.
REQ-004 kill  input  1  synchronous abort, active-high.
REQ-005 in_valid  input  1  plaintext block offered.
REQ-006 in_ready  output  1  block can accept plaintext.
REQ-007 in_data  input  128  plaintext, byte 0 in bits [127:120].
REQ-008 key_idx  output  4  index of the round key requested this cycle.
REQ-009 key_round  input  128  round key for key_idx, supplied combinationally in the same cycle.
REQ-010 out_valid  output  1  ciphertext available.
REQ-011 out_ready  input  1  consumer accepts ciphertext.
REQ-012 out_data  output  128  ciphertext, same byte order as in_data.
REQ-013 busy  output  1  high in any state other than IDLE.

Function
REQ-014 The FSM SHALL have exactly the states IDLE, SUB, MIX, ADD and DONE, plus a 4-bit round counter rnd.
REQ-015 In IDLE: in_ready=1, key_idx=0; when in_valid=1, the block SHALL load state <= in_data ^ key_round, set rnd=1 and go to SUB.
REQ-016 In SUB: stage1 <= ShiftRows(SubBytes(state)) using the FIPS-197 S-box; go to MIX.
REQ-017 In MIX: stage2 <= MixColumns(stage1) when rnd<NR, stage2 <= stage1 when rnd==NR (final round has no MixColumns); go to ADD.
REQ-018 In ADD: key_idx=rnd and state <= stage2 ^ key_round; if rnd==NR go to DONE, else rnd <= rnd+1 and go to SUB.
REQ-019 In DONE: out_valid=1, out_data=state held stable; when out_ready=1, go to IDLE with out_valid low on the next cycle.
REQ-020 Latency SHALL be 3*NR cycles, counted from the accepting edge to the edge at which out_valid rises (30 cycles for NR=10, 42 for NR=14).
REQ-021 in_ready SHALL be 0 in SUB, MIX, ADD and DONE, so no new block is accepted until the output handshake completes.
REQ-022 Back-to-back operation: an accept is possible in the first IDLE cycle after DONE, giving a minimum issue interval of 3*NR+2 cycles.
REQ-023 When not in IDLE or ADD, key_idx SHALL hold the current rnd value, and key_round SHALL be ignored.
REQ-024 out_data SHALL always equal the state register; its value is defined only while out_valid=1.
REQ-025 kill=1 at a clock edge SHALL force IDLE, rnd=0, state=stage1=stage2=0 and out_valid=0, regardless of state.
REQ-026 kill SHALL take priority over in_valid and over out_ready in the same cycle.
REQ-027 in_valid deasserting while the block is busy SHALL have no effect, and out_ready in any state but DONE SHALL be ignored.
REQ-028 GF(2^8) multiplication SHALL use the polynomial x^8+x^4+x^3+x+1.

Reset
REQ-029 While kill_n=0, the block SHALL be in IDLE with rnd=0, state/stage1/stage2=0, out_valid=0, busy=0 and in_ready=1.
REQ-030 Assertion of kill_n=0 mid-operation SHALL abandon the block immediately, and no out_valid SHALL follow.
REQ-031 Deassertion of kill_n SHALL be synchronised externally; the first accept is legal on the first edge after release.

Verification
REQ-032 NR=10, key 2b7e151628aed2a6abf7158809cf4f3c (bench supplies expanded keys per key_idx), in_data 3243f6a8885a308d313198a2e0370734 -> out_valid after 30 cycles, out_data 3925841d02dc09fbdc118597196a0b32.
REQ-033 NR=10, key 000102030405060708090a0b0c0d0e0f, in_data 00112233445566778899aabbccddeeff -> out_data 69c4e0d86a7b0430d8cdb78070b4c55a; with out_ready held 0 for 5 cycles -> out_valid and out_data stable, in_ready=0 throughout.
REQ-034 NR=14, key 000102...1e1f, same plaintext as REQ-033 -> out_data 8ea2b7ca516745bfeafc49904b496089 after 42 cycles; key_idx sequence 0,1..14 observed in the ADD cycles.
REQ-035 kill=1 in the MIX state of round 5 -> next cycle IDLE, in_ready=1, out_valid never asserted; the following block encrypts correctly.
REQ-036 kill_n pulsed low during round 3 -> outputs immediately at reset values; recovery as in REQ-035.
REQ-037 Two blocks issued back-to-back with out_ready=1 -> second accept exactly 32 cycles after the first (NR=10), both ciphertexts correct.
